// File: rtl/merlin_mtimer_pkg.sv
// merlin_mtimer_pkg: register offsets, CTRL field positions and reset constants
// shared by the machine timer and its response buffer.
package merlin_mtimer_pkg;

  // Byte offsets within the 32-byte window (only addr[4:2] is decoded).
  localparam logic [4:0] C_OFS_MTIME_LO    = 5'h00;
  localparam logic [4:0] C_OFS_MTIME_HI    = 5'h04;
  localparam logic [4:0] C_OFS_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] C_OFS_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] C_OFS_CTRL        = 5'h10;

  // CTRL fields
  localparam int C_CTRL_EN_BIT    = 0;
  localparam int C_CTRL_PRESC_LSB = 8;

  // mtimecmp comes out of reset at its maximum so no interrupt fires early.
  localparam logic [63:0] C_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Word-aligned byte offset of a bus address.
  function automatic logic [4:0] word_ofs(input logic [31:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/merlin_mtimer_rspbuf.sv
// merlin_mtimer_rspbuf: single-entry read response register with valid/ready.
// Ports: clk/reset/clk_en; load + load_data capture a read result; rsp_ready
// drains it; req_ready tells the requester a new read can be absorbed.
module merlin_mtimer_rspbuf (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        rsp_ready,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data
);

  // The slot is free when empty or when it is being drained this cycle,
  // which sustains one read per cycle while the consumer keeps ready high.
  assign req_ready = ~rsp_valid | rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (clk_en) begin
      if (load) begin
        rsp_valid <= 1'b1;
        rsp_data  <= load_data;
      end else if (rsp_ready) begin
        // Data is left in place; only valid drops.
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/merlin_mtimer.sv
// merlin_mtimer: RISC-V machine timer (64-bit mtime with prescaler, mtimecmp,
// registered level interrupt) as a data-port slave.
// Ports: clk_i/clk_en_i/reset_i; treq* request channel (dvalid=1 write, 0 read);
// trsp* read response channel; irq_timer_o = registered (mtime >= mtimecmp).
module merlin_mtimer
  import merlin_mtimer_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDR = 32'h0000_1000,
  parameter int          C_PRESC_W   = 8
) (
  input  logic        clk_i,
  input  logic        clk_en_i,
  input  logic        reset_i,
  output logic        treqready_o,
  input  logic        treqvalid_i,
  input  logic        treqdvalid_i,
  input  logic [31:0] treqaddr_i,
  input  logic [31:0] treqdata_i,
  input  logic        trspready_i,
  output logic        trspvalid_o,
  output logic [31:0] trspdata_o,
  output logic        irq_timer_o
);

  logic [63:0]          mtime;
  logic [63:0]          mtime_nxt;
  logic [63:0]          mtimecmp;
  logic [31:0]          shadow;
  logic                 ctrl_en;
  logic [C_PRESC_W-1:0] ctrl_presc;
  logic [C_PRESC_W-1:0] presc_cnt;
  logic                 tick;

  logic        accept;
  logic        wr_acc;
  logic        rd_acc;
  logic [4:0]  ofs;
  logic [31:0] rd_data;

  // Block selection is done externally; base address and upper/lower address
  // bits are intentionally ignored here.
  logic unused_bits;
  assign unused_bits = ^{C_BASE_ADDR, treqaddr_i[31:5], treqaddr_i[1:0]};

  assign accept = treqvalid_i & treqready_o & clk_en_i;
  assign wr_acc = accept &  treqdvalid_i;
  assign rd_acc = accept & ~treqdvalid_i;
  assign ofs    = word_ofs(treqaddr_i);

  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, rd_mtime_lo;
  assign wr_mtime_lo = wr_acc & (ofs == C_OFS_MTIME_LO);
  assign wr_mtime_hi = wr_acc & (ofs == C_OFS_MTIME_HI);
  assign wr_cmp_lo   = wr_acc & (ofs == C_OFS_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_acc & (ofs == C_OFS_MTIMECMP_HI);
  assign wr_ctrl     = wr_acc & (ofs == C_OFS_CTRL);
  assign rd_mtime_lo = rd_acc & (ofs == C_OFS_MTIME_LO);

  assign tick = ctrl_en & (presc_cnt == ctrl_presc);

  // A write to one half of mtime replaces that half and leaves the other at
  // its pre-tick value, so a coincident tick (and its carry) is discarded.
  always_comb begin
    mtime_nxt = mtime + 64'(tick);
    if (wr_mtime_lo) begin
      mtime_nxt = {mtime[63:32], treqdata_i};
    end else if (wr_mtime_hi) begin
      mtime_nxt = {treqdata_i, mtime[31:0]};
    end
  end

  // Read data reflects register state before any same-cycle update.
  always_comb begin
    rd_data = '0;
    case (ofs)
      C_OFS_MTIME_LO:    rd_data = mtime[31:0];
      C_OFS_MTIME_HI:    rd_data = shadow;
      C_OFS_MTIMECMP_LO: rd_data = mtimecmp[31:0];
      C_OFS_MTIMECMP_HI: rd_data = mtimecmp[63:32];
      C_OFS_CTRL: begin
        rd_data[C_CTRL_EN_BIT]                    = ctrl_en;
        rd_data[C_CTRL_PRESC_LSB +: C_PRESC_W]    = ctrl_presc;
      end
      default:           rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mtime       <= '0;
      mtimecmp    <= C_MTIMECMP_RST;
      shadow      <= '0;
      ctrl_en     <= 1'b0;
      ctrl_presc  <= '0;
      presc_cnt   <= '0;
      irq_timer_o <= 1'b0;
    end else if (clk_en_i) begin
      mtime <= mtime_nxt;

      if (wr_ctrl) begin
        presc_cnt <= '0;
      end else if (ctrl_en) begin
        presc_cnt <= tick ? '0 : presc_cnt + C_PRESC_W'(1);
      end

      if (wr_ctrl) begin
        ctrl_en    <= treqdata_i[C_CTRL_EN_BIT];
        ctrl_presc <= treqdata_i[C_CTRL_PRESC_LSB +: C_PRESC_W];
      end

      if (wr_cmp_lo) mtimecmp[31:0]  <= treqdata_i;
      if (wr_cmp_hi) mtimecmp[63:32] <= treqdata_i;

      // Shadow lets software read a consistent 64-bit value: LO first, then HI.
      if (wr_mtime_hi) begin
        shadow <= treqdata_i;
      end else if (rd_mtime_lo) begin
        shadow <= mtime[63:32];
      end

      irq_timer_o <= (mtime >= mtimecmp);
    end
  end

  merlin_mtimer_rspbuf u_rspbuf (
    .clk       (clk_i),
    .reset     (reset_i),
    .clk_en    (clk_en_i),
    .load      (rd_acc),
    .load_data (rd_data),
    .rsp_ready (trspready_i),
    .req_ready (treqready_o),
    .rsp_valid (trspvalid_o),
    .rsp_data  (trspdata_o)
  );

endmodule

// File: tb/tb_merlin_mtimer.sv
// tb_merlin_mtimer: randomized and directed stimulus against a behavioural
// timer model, with literal expectations for the directed scenarios.
module tb_merlin_mtimer;

  logic        clk_i = 1'b0;
  logic        clk_en_i = 1'b1;
  logic        reset_i = 1'b0;
  logic        treqready_o;
  logic        treqvalid_i = 1'b0;
  logic        treqdvalid_i = 1'b0;
  logic [31:0] treqaddr_i = '0;
  logic [31:0] treqdata_i = '0;
  logic        trspready_i = 1'b1;
  logic        trspvalid_o;
  logic [31:0] trspdata_o;
  logic        irq_timer_o;

  merlin_mtimer dut (
    .clk_i        (clk_i),
    .clk_en_i     (clk_en_i),
    .reset_i      (reset_i),
    .treqready_o  (treqready_o),
    .treqvalid_i  (treqvalid_i),
    .treqdvalid_i (treqdvalid_i),
    .treqaddr_i   (treqaddr_i),
    .treqdata_i   (treqdata_i),
    .trspready_i  (trspready_i),
    .trspvalid_o  (trspvalid_o),
    .trspdata_o   (trspdata_o),
    .irq_timer_o  (irq_timer_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rsp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow, m_dat;
  logic        m_en, m_vld, m_irq;
  int          m_presc, m_wait;   // m_wait = enabled cycles since last increment

  task automatic model_step();
    logic        acc;
    int          idx;
    logic [31:0] d, rd;
    logic [63:0] old;
    if (reset_i) begin
      m_mtime = 0; m_cmp = '1; m_shadow = 0; m_en = 0; m_presc = 0; m_wait = 0;
      m_vld = 0; m_dat = 0; m_irq = 0;
      return;
    end
    if (!clk_en_i) return;
    acc = treqvalid_i && (!m_vld || trspready_i);
    idx = int'(treqaddr_i[4:2]);
    d   = treqdata_i;
    old = m_mtime;
    case (idx)
      0: rd = old[31:0];
      1: rd = m_shadow;
      2: rd = m_cmp[31:0];
      3: rd = m_cmp[63:32];
      4: rd = (32'(m_presc) << 8) | 32'(m_en);
      default: rd = 0;
    endcase
    m_irq = (old >= m_cmp);
    // One increment every PRESC+1 enabled cycles.
    if (m_en) begin
      if (m_wait == m_presc) begin
        m_mtime = old + 1;
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end
    if (acc && treqdvalid_i) begin
      case (idx)
        0: m_mtime = {old[63:32], d};
        1: begin m_mtime = {d, old[31:0]}; m_shadow = d; end
        2: m_cmp[31:0] = d;
        3: m_cmp[63:32] = d;
        4: begin m_en = d[0]; m_presc = int'(d[15:8]); m_wait = 0; end
        default: ;
      endcase
    end
    if (acc && !treqdvalid_i) begin
      m_vld = 1; m_dat = rd;
      if (idx == 0) m_shadow = old[63:32];
    end else if (trspready_i) begin
      m_vld = 0;
    end
  endtask

  initial forever begin
    @(posedge clk_i or posedge reset_i);
    model_step();
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk_i);
    #3;
    if (!reset_i) begin
      chk("treqready", treqready_o, !m_vld || trspready_i);
      chk("trspvalid", trspvalid_o, m_vld);
      if (m_vld) chk("trspdata", trspdata_o, m_dat);
      chk("irq", irq_timer_o, m_irq);
      if (trspvalid_o && trspready_i && clk_en_i) rsp_q.push_back(trspdata_o);
    end
  end

  // ---------------- stimulus helpers (phase: negedge + 1) ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic idle();
    treqvalid_i = 1'b0;
    treqdvalid_i = 1'b0;
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int waited;
    waited = 0;
    treqvalid_i = 1'b1; treqdvalid_i = wr; treqaddr_i = addr; treqdata_i = data;
    #1;
    while (!(treqready_o && clk_en_i) && waited < 50) begin
      @(negedge clk_i); #2; waited++;
    end
    if (waited >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: treqready_o=%0b, required 1", treqready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i); #1;
  endtask

  task automatic read_lit(input logic [31:0] addr, output logic [31:0] d);
    rsp_q.delete();
    req(1'b0, addr, 32'h0);
    idle();
    cycles(1);
    if (rsp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: no response for addr %0h, required one", addr);
      d = 'x;
    end else begin
      d = rsp_q.pop_front();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d;
    int last_chg, n_chg;
    #1 reset_i = 1'b1;
    #2;
    chk("rst_trspvalid", trspvalid_o, 0);
    chk("rst_trspdata", trspdata_o, 0);
    chk("rst_irq", irq_timer_o, 0);
    chk("rst_treqready", treqready_o, 1);
    @(negedge clk_i); #1 reset_i = 1'b0;

    // Reset values of mtimecmp
    read_lit(32'h1008, d); chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
    read_lit(32'h100C, d); chk("rst_cmp_hi", d, 32'hFFFF_FFFF);
    chk("rst_irq_after", irq_timer_o, 0);

    // Prescaler = 3: one increment every 4 cycles
    req(1'b1, 32'h1010, 32'h0000_0301); idle();
    cycles(40);
    read_lit(32'h1000, d); chk("presc_mtime", d, 10);
    rsp_q.delete();
    repeat (12) req(1'b0, 32'h1000, 0);
    idle(); cycles(1);
    chk("b2b_count", rsp_q.size(), 12);
    last_chg = -1; n_chg = 0;
    for (int i = 1; i < rsp_q.size(); i++) begin
      if (rsp_q[i] != rsp_q[i-1]) begin
        chk("presc_step", rsp_q[i] - rsp_q[i-1], 1);
        if (last_chg >= 0) chk("presc_spacing", i - last_chg, 4);
        last_chg = i; n_chg++;
      end
    end
    chk("presc_changes_seen", n_chg >= 2, 1);

    // Carry into the high word and shadowed HI read
    req(1'b1, 32'h1010, 0);
    req(1'b1, 32'h1000, 32'hFFFF_FFFE);
    req(1'b1, 32'h1004, 0);
    req(1'b1, 32'h1010, 1); idle();
    cycles(3);
    read_lit(32'h1000, d); chk("carry_lo", d, 1);
    cycles(2);
    read_lit(32'h1004, d); chk("carry_hi_shadow", d, 1);

    // Compare / interrupt timing
    req(1'b1, 32'h1010, 0);
    req(1'b1, 32'h1000, 0);
    req(1'b1, 32'h1004, 0);
    req(1'b1, 32'h1008, 20);
    req(1'b1, 32'h100C, 0);
    req(1'b1, 32'h1010, 1); idle();
    cycles(20); #2; chk("irq_before", irq_timer_o, 0);
    @(negedge clk_i); #1;
    #2; chk("irq_rise", irq_timer_o, 1);
    @(negedge clk_i); #1;
    req(1'b1, 32'h100C, 1); idle();
    #2; chk("irq_hold", irq_timer_o, 1);
    @(negedge clk_i); #1;
    #2; chk("irq_fall", irq_timer_o, 0);
    @(negedge clk_i); #1;

    // Backpressure: second read stalls, first data held
    rsp_q.delete();
    trspready_i = 1'b0;
    req(1'b0, 32'h1008, 0);
    treqaddr_i = 32'h100C;
    repeat (3) begin
      #2;
      chk("stall_ready", treqready_o, 0);
      chk("stall_data", trspdata_o, 20);
      @(negedge clk_i); #1;
    end
    trspready_i = 1'b1;
    req(1'b0, 32'h100C, 0); idle();
    cycles(2);
    chk("drain_count", rsp_q.size(), 2);
    if (rsp_q.size() == 2) begin
      chk("drain_first", rsp_q[0], 20);
      chk("drain_second", rsp_q[1], 1);
    end

    // Reset in the middle of a pending response
    req(1'b1, 32'h100C, 0); idle();
    cycles(2);
    trspready_i = 1'b0;
    req(1'b0, 32'h1000, 0); idle();
    cycles(1);
    chk("pre_rst_valid", trspvalid_o, 1);
    chk("pre_rst_irq", irq_timer_o, 1);
    reset_i = 1'b1;
    #1;
    chk("async_rst_valid", trspvalid_o, 0);
    chk("async_rst_irq", irq_timer_o, 0);
    @(negedge clk_i); #1;
    reset_i = 1'b0; trspready_i = 1'b1;
    read_lit(32'h1000, d); chk("post_rst_mtime", d, 0);
    read_lit(32'h1010, d); chk("post_rst_ctrl", d, 0);

    // Randomized traffic checked cycle-by-cycle against the model
    repeat (600) begin
      clk_en_i     = ($urandom_range(0, 7) != 0);
      trspready_i  = ($urandom_range(0, 3) != 0);
      treqvalid_i  = $urandom_range(0, 1) == 1;
      treqdvalid_i = ($urandom_range(0, 2) == 0);
      treqaddr_i   = ($urandom & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2);
      case ($urandom_range(0, 3))
        0: treqdata_i = $urandom;
        1: treqdata_i = 32'($urandom_range(0, 40));
        2: treqdata_i = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: treqdata_i = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 1));
      endcase
      @(negedge clk_i); #1;
    end
    idle(); clk_en_i = 1'b1; trspready_i = 1'b1;
    cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
